// File: rtl/bcd_sub_if.sv
// Handshake and operand bundle for the serial BCD subtractor.
// The requester drives start/a/b; the subtractor returns status and result.
interface bcd_sub_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   diff;
    logic                  negative;
    logic                  invalid;

    modport master (
        output start, a, b,
        input  busy, done, diff, negative, invalid
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, negative, invalid
    );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD subtractor computing A-B one digit per clock (LSB first);
// a negative result is turned into sign+magnitude by a ten's-complement pass.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    bcd_sub_if.slave    bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, COMP, FIN} state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, b_reg, diff_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               borrow_reg, negative_reg, invalid_reg;

    logic [DIGITS-1:0]  nibble_bad;
    logic               any_bad;
    logic               last_digit;
    logic [3:0]         x_dig, y_dig, res_dig;
    logic [4:0]         t;
    logic               borrow_out;

    // Operand validity is judged on the live inputs, at the moment start is accepted.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
        assign nibble_bad[gi] = (bus.a[4*gi +: 4] > 4'd9) || (bus.b[4*gi +: 4] > 4'd9);
    end
    assign any_bad    = |nibble_bad;
    assign last_digit = (idx_reg == IDX_W'(DIGITS - 1));

    // Shared digit cell: SUB computes a_i - b_i, COMP computes 0 - diff_i.
    always_comb begin
        x_dig      = (state_reg == COMP) ? 4'd0 : a_reg[idx_reg*4 +: 4];
        y_dig      = (state_reg == COMP) ? diff_reg[idx_reg*4 +: 4] : b_reg[idx_reg*4 +: 4];
        t          = {1'b0, x_dig} - {1'b0, y_dig} - {4'b0000, borrow_reg};
        borrow_out = t[4];
        res_dig    = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (bus.start) state_next = any_bad ? FIN : SUB;
            SUB:  if (last_digit) state_next = borrow_out ? COMP : FIN;
            COMP: if (last_digit) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_reg != IDLE);
        bus.done = (state_reg == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            diff_reg     <= '0;
            idx_reg      <= '0;
            borrow_reg   <= 1'b0;
            negative_reg <= 1'b0;
            invalid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        diff_reg     <= '0;
                        idx_reg      <= '0;
                        borrow_reg   <= 1'b0;
                        negative_reg <= 1'b0;
                        invalid_reg  <= any_bad;
                    end
                end
                SUB: begin
                    diff_reg[idx_reg*4 +: 4] <= res_dig;
                    if (last_digit) begin
                        // A final borrow means A < B: restart the index for the complement pass.
                        idx_reg      <= '0;
                        borrow_reg   <= 1'b0;
                        negative_reg <= borrow_out;
                    end else begin
                        idx_reg    <= idx_reg + IDX_W'(1);
                        borrow_reg <= borrow_out;
                    end
                end
                COMP: begin
                    diff_reg[idx_reg*4 +: 4] <= res_dig;
                    borrow_reg <= last_digit ? 1'b0 : borrow_out;
                    idx_reg    <= last_digit ? '0 : (idx_reg + IDX_W'(1));
                end
                default: ;
            endcase
        end
    end

    assign bus.diff     = diff_reg;
    assign bus.negative = negative_reg;
    assign bus.invalid  = invalid_reg;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor (DIGITS=4): directed plan vectors plus random
// operands, checked against an integer-arithmetic reference model.
module tb_bcd_serial_subtractor;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bcd_sub_if #(.DIGITS(D)) bus ();

    bcd_serial_subtractor #(.DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: decode decimal values, subtract as integers, re-encode the magnitude.
    function automatic void model(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                                  output logic [4*D-1:0] d, output logic n,
                                  output logic inv, output int lat);
        int ai, bi, r, p;
        logic [3:0] na, nb;
        ai = 0; bi = 0; inv = 1'b0; p = 1;
        for (int i = 0; i < D; i++) begin
            na = av[4*i +: 4];
            nb = bv[4*i +: 4];
            if (na > 4'd9 || nb > 4'd9) inv = 1'b1;
            ai = ai + int'(na) * p;
            bi = bi + int'(nb) * p;
            p = p * 10;
        end
        d = '0;
        n = 1'b0;
        if (inv) begin
            lat = 1;
        end else begin
            r = ai - bi;
            n = (r < 0);
            if (r < 0) r = -r;
            for (int i = 0; i < D; i++) begin
                d[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
            lat = n ? (2*D + 1) : (D + 1);
        end
    endfunction

    // Issues one start pulse and observes 30 cycles afterwards.
    task automatic run_op(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                          output logic [4*D-1:0] d, output logic n, output logic inv,
                          output int lat, output int ndone, output logic busy_after,
                          output logic [4*D-1:0] held);
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        d = '0; n = 1'b0; inv = 1'b0; lat = -1; ndone = 0; busy_after = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            if (bus.done) begin
                if (ndone == 0) begin
                    lat = c; d = bus.diff; n = bus.negative; inv = bus.invalid;
                end
                ndone++;
            end
            if (lat > 0 && c == lat + 1) busy_after = bus.busy;
            if (c < 30) @(negedge clk);
        end
        held = bus.diff;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.negative, bus.invalid} !== 4'b0000 || bus.diff !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b neg=%b inv=%b diff=%h, required all zero",
                     bus.busy, bus.done, bus.negative, bus.invalid, bus.diff);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [4*D-1:0] va [7] = '{16'h0753, 16'h0129, 16'h1000, 16'h0000, 16'h12A4, 16'h9999, 16'h0000};
        logic [4*D-1:0] vb [7] = '{16'h0129, 16'h0753, 16'h0001, 16'h0001, 16'h0001, 16'h9999, 16'h9999};
        logic [4*D-1:0] ed, gd, held;
        logic en, einv, gn, ginv, gbusy;
        int elat, glat, gdone;
        for (int i = 0; i < 7; i++) begin
            model(va[i], vb[i], ed, en, einv, elat);
            run_op(va[i], vb[i], gd, gn, ginv, glat, gdone, gbusy, held);
            $display("directed %0d: a=%h b=%h -> diff=%h neg=%b inv=%b lat=%0d dones=%0d",
                     i, va[i], vb[i], gd, gn, ginv, glat, gdone);
            checks += 6;
            if (glat !== elat || gdone !== 1) begin errors++;
                $display("FAIL directed_latency %0d: got lat=%0d dones=%0d, required lat=%0d dones=1", i, glat, gdone, elat); end
            if (gd !== ed) begin errors++;
                $display("FAIL directed_diff %0d: got %h, required %h", i, gd, ed); end
            if (gn !== en) begin errors++;
                $display("FAIL directed_negative %0d: got %b, required %b", i, gn, en); end
            if (ginv !== einv) begin errors++;
                $display("FAIL directed_invalid %0d: got %b, required %b", i, ginv, einv); end
            if (gbusy !== 1'b0) begin errors++;
                $display("FAIL directed_busy_after_done %0d: got %b, required 0", i, gbusy); end
            if (held !== ed) begin errors++;
                $display("FAIL directed_hold %0d: got %h, required %h", i, held, ed); end
        end
    endtask

    task automatic test_random();
        logic [4*D-1:0] av, bv, ed, gd, held;
        logic en, einv, gn, ginv, gbusy;
        int elat, glat, gdone;
        for (int i = 0; i < 40; i++) begin
            av = '0; bv = '0;
            for (int k = 0; k < D; k++) begin
                av[4*k +: 4] = 4'($urandom_range(0, 9));
                bv[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 9) == 0) av[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) bv = av;
            model(av, bv, ed, en, einv, elat);
            run_op(av, bv, gd, gn, ginv, glat, gdone, gbusy, held);
            $display("random %0d: a=%h b=%h -> diff=%h neg=%b inv=%b lat=%0d", i, av, bv, gd, gn, ginv, glat);
            checks += 3;
            if (glat !== elat || gdone !== 1) begin errors++;
                $display("FAIL random_latency %0d: got lat=%0d dones=%0d, required lat=%0d dones=1", i, glat, gdone, elat); end
            if (gd !== ed || held !== ed) begin errors++;
                $display("FAIL random_diff %0d: got %h (held %h), required %h", i, gd, held, ed); end
            if (gn !== en || ginv !== einv) begin errors++;
                $display("FAIL random_flags %0d: got neg=%b inv=%b, required neg=%b inv=%b", i, gn, ginv, en, einv); end
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0, lat = -1;
        logic [4*D-1:0] gd = '0;
        logic busy_after = 1'b1;
        @(negedge clk);
        bus.a = 16'h5000; bus.b = 16'h0001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 2) begin bus.a = 16'h0001; bus.b = 16'h0002; bus.start = 1'b1; end
            if (c == 3) bus.start = 1'b0;
            if (bus.done) begin
                if (ndone == 0) begin lat = c; gd = bus.diff; end
                ndone++;
            end
            if (lat > 0 && c == lat + 1) busy_after = bus.busy;
            if (c < 25) @(negedge clk);
        end
        $display("back_to_back: dones=%0d lat=%0d diff=%h", ndone, lat, gd);
        checks += 3;
        if (ndone !== 1 || lat !== D + 1) begin errors++;
            $display("FAIL b2b_done: got dones=%0d lat=%0d, required 1 at %0d", ndone, lat, D + 1); end
        if (gd !== 16'h4999) begin errors++;
            $display("FAIL b2b_diff: got %h, required 4999", gd); end
        if (busy_after !== 1'b0) begin errors++;
            $display("FAIL b2b_busy: got %b, required 0", busy_after); end
    endtask

    task automatic test_reset_midop();
        int ndone = 0;
        logic [4*D-1:0] gd, held;
        logic gn, ginv, gbusy;
        int glat, gdone;
        @(negedge clk);
        bus.a = 16'h0129; bus.b = 16'h0753; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (D + 1) @(negedge clk);   // now in the complement pass
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.negative, bus.invalid} !== 4'b0000 || bus.diff !== '0) begin
            errors++;
            $display("FAIL midop_reset: busy=%b done=%b neg=%b inv=%b diff=%h, required all zero",
                     bus.busy, bus.done, bus.negative, bus.invalid, bus.diff);
        end
        for (int c = 0; c < 12; c++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 0) begin errors++;
            $display("FAIL midop_no_done: got %0d done pulses, required 0", ndone); end
        run_op(16'h0129, 16'h0753, gd, gn, ginv, glat, gdone, gbusy, held);
        $display("reset_midop restart: diff=%h neg=%b lat=%0d", gd, gn, glat);
        checks++;
        if (gd !== 16'h0624 || gn !== 1'b1 || ginv !== 1'b0 || glat !== 2*D + 1 || gdone !== 1) begin errors++;
            $display("FAIL midop_restart: got diff=%h neg=%b inv=%b lat=%0d dones=%0d, required 0624/1/0/%0d/1",
                     gd, gn, ginv, glat, gdone, 2*D + 1); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_serial_subtractor.md
Name: bcd_serial_subtractor

Overview:
- Multi-digit packed-BCD subtractor, the inverse of the team's combinational BCD adder.
- Computes A − B one decimal digit per clock, LSB digit first, with a borrow chain.
- A negative result is converted to sign plus magnitude by a second ten's-complement pass.
- Used by decimal datapaths (counters, displays, calculators) that need compact, area-cheap subtraction under a start/done handshake.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock; the block's single clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0]
- b  input  4*DIGITS  subtrahend, packed BCD
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle completion pulse
- diff  output  4*DIGITS  magnitude of A−B, packed BCD
- negative  output  1  1 when A < B
- invalid  output  1  1 when any input digit > 9

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy, done, negative, invalid = 0; diff = 0; operand registers and digit counter cleared. Reset overrides every other input, including mid-operation; no done pulse follows.
- States: IDLE, SUB, COMP, FIN.
- IDLE:
  - start=1 latches a and b, clears diff/negative/invalid and the borrow, and sets digit index = 0.
  - If any nibble of a or b is > 9, go to FIN with invalid=1; otherwise go to SUB.
- SUB: one digit i per cycle, t = a_i − b_i − borrow (signed, 5-bit).
  - If t < 0: digit = t + 10, borrow = 1. Else digit = t, borrow = 0.
  - Write the digit into diff nibble i.
  - After digit DIGITS−1: final borrow=0 → FIN; final borrow=1 → set negative=1, clear borrow, index=0, go to COMP.
- COMP: one digit per cycle, t = 0 − diff_i − borrow, same correction rule, result written back to diff nibble i. After digit DIGITS−1, go to FIN.
  - Result is the ten's complement, i.e. the |A−B| magnitude.
- FIN: done=1 for exactly this cycle, then go to IDLE.
- Latency, with start accepted at edge k:
  - done high in cycle k+1 when invalid.
  - done high in cycle k+DIGITS+1 when non-negative.
  - done high in cycle k+2*DIGITS+1 when negative.
- Output validity:
  - diff may show partial digits while busy=1.
  - diff, negative and invalid are final when done=1 and hold until the next accepted start.
  - When invalid=1: diff=0 and negative=0.
- start while busy=1, including the FIN cycle, is ignored with no queuing. a and b may change freely after acceptance.
- Equal operands give diff=0 and negative=0; a zero result is never flagged negative.
- Arithmetic is modulo 10^DIGITS per pass. No overflow is possible, since |A−B| < 10^DIGITS.

Test Plan (DIGITS=4):
- a=0x0753, b=0x0129, start for 1 cycle → done exactly 5 cycles later, diff=0x0624, negative=0, invalid=0.
- a=0x0129, b=0x0753 → done 9 cycles after start, diff=0x0624, negative=1.
- Borrow ripple: a=0x1000, b=0x0001 → diff=0x0999, negative=0. Also a=0x0000, b=0x0001 → diff=0x0001, negative=1.
- Invalid: a=0x12A4, b=0x0001 → done 1 cycle later, invalid=1, diff=0x0000, negative=0. Also a=0x9999, b=0x9999 → diff=0x0000, negative=0.
- Handshake: pulse start with a=0x5000, b=0x0001, then pulse start again 2 cycles later with a=0x0001, b=0x0002 → second start ignored; single done with diff=0x4999; busy low the cycle after done.
- Reset mid-op: start a=0x0129, b=0x0753, assert rst during COMP → next cycle all outputs 0, no done pulse. A new start afterwards completes normally.
